// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : calc_pkg                                                       |
// | Purpose   : Shared key codes, entry-state encodings and width helper for  |
// |             the calculator operand loader.                                 |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package calc_pkg;

  localparam logic [3:0] KEY_DIG_MAX = 4'h9;
  localparam logic [3:0] KEY_PLUS    = 4'hA;
  localparam logic [3:0] KEY_MINUS   = 4'hB;
  localparam logic [3:0] KEY_NEG     = 4'hC;
  localparam logic [3:0] KEY_EQ      = 4'hD;
  localparam logic [3:0] KEY_CLR     = 4'hE;
  localparam logic [3:0] KEY_NOP     = 4'hF;

  localparam logic [1:0] ST_A_ENT    = 2'd0;
  localparam logic [1:0] ST_B_ENT    = 2'd1;
  localparam logic [1:0] ST_PRESENT  = 2'd2;

  // Operand width: sign bit on top of the magnitude.
  function automatic int calc_opw(input int mag_w);
    return mag_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/calc_key_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : calc_key_fifo                                                  |
// | Purpose   : Small synchronous FIFO buffering key codes ahead of the entry  |
// |             FSM; only instantiated when CALC_KEY_FIFO_EN is defined.       |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module calc_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Storage needs no reset; only pointers and occupancy define contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc_operand_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : calc_operand_loader                                            |
// | Purpose   : Key-entry front end for add_sub; assembles {a1, b1, add_sub}   |
// |             and presents it under a valid/ready handshake.                 |
// |             Optional key FIFO enabled by macro CALC_KEY_FIFO_EN.           |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module calc_operand_loader
  import calc_pkg::*;
#(
  parameter int MAG_W      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  output logic                   key_ready,
  input  logic [3:0]             key_code,
  output logic [calc_opw(MAG_W)-1:0] a1,
  output logic [calc_opw(MAG_W)-1:0] b1,
  output logic                   add_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err,
  output logic [1:0]             entry_st
);

  localparam int N_DIGITS = ((1 << MAG_W) < 10) ? (1 << MAG_W) : 10;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [1:0]       state_q,   state_d;
  logic [MAG_W-1:0] a_mag_q,   a_mag_d;
  logic [MAG_W-1:0] b_mag_q,   b_mag_d;
  logic             a_sign_q,  a_sign_d;
  logic             b_sign_q,  b_sign_d;
  logic             a_seen_q,  a_seen_d;
  logic             b_seen_q,  b_seen_d;
  logic             add_sub_q, add_sub_d;
  logic             err_q,     err_d;

  logic             in_entry;
  logic             fsm_valid;
  logic [3:0]       fsm_code;
  logic             fsm_take;
  logic             key_is_digit;
  logic             digit_ok;
  logic [MAG_W-1:0] key_digit;
  logic             clr_all;

  assign in_entry = (state_q != ST_PRESENT);

`ifdef CALC_KEY_FIFO_EN
  logic       fifo_full;
  logic       fifo_empty;
  logic [3:0] fifo_rdata;

  calc_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_key_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (key_valid && !fifo_full),
    .wdata (key_code),
    .pop   (fsm_take),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign key_ready = !fifo_full;
  assign fsm_valid = !fifo_empty;
  assign fsm_code  = fifo_rdata;
`else
  assign key_ready = in_entry;
  assign fsm_valid = key_valid;
  assign fsm_code  = key_code;
`endif

  assign fsm_take     = fsm_valid && in_entry;
  assign key_is_digit = (fsm_code <= KEY_DIG_MAX);
  assign digit_ok     = ({28'd0, fsm_code} < 32'(N_DIGITS));
  assign key_digit    = MAG_W'(fsm_code);

  always_comb begin
    state_d   = state_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    a_sign_d  = a_sign_q;
    b_sign_d  = b_sign_q;
    a_seen_d  = a_seen_q;
    b_seen_d  = b_seen_q;
    add_sub_d = add_sub_q;
    err_d     = 1'b0;
    clr_all   = 1'b0;

    if (state_q == ST_PRESENT) begin
      clr_all = out_ready;
    end else if (fsm_take) begin
      if (key_is_digit) begin
        if (!digit_ok) begin
          err_d = 1'b1;
        end else if (state_q == ST_A_ENT) begin
          a_mag_d  = key_digit;
          a_seen_d = 1'b1;
        end else begin
          b_mag_d  = key_digit;
          b_seen_d = 1'b1;
        end
      end else begin
        case (fsm_code)
          KEY_NEG: begin
            if (state_q == ST_A_ENT) a_sign_d = !a_sign_q;
            else                     b_sign_d = !b_sign_q;
          end
          KEY_PLUS, KEY_MINUS: begin
            // The operator stays editable in B_ENT until B's first digit.
            if (state_q == ST_A_ENT) begin
              if (a_seen_q) begin
                add_sub_d = (fsm_code == KEY_MINUS);
                state_d   = ST_B_ENT;
              end
            end else if (!b_seen_q) begin
              add_sub_d = (fsm_code == KEY_MINUS);
            end
          end
          KEY_EQ: begin
            if (state_q == ST_B_ENT && b_seen_q) state_d = ST_PRESENT;
          end
          KEY_CLR: clr_all = 1'b1;
          default: ;
        endcase
      end
    end

    if (clr_all) begin
      state_d   = ST_A_ENT;
      a_mag_d   = '0;
      b_mag_d   = '0;
      a_sign_d  = 1'b0;
      b_sign_d  = 1'b0;
      a_seen_d  = 1'b0;
      b_seen_d  = 1'b0;
      add_sub_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_A_ENT;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      a_sign_q  <= 1'b0;
      b_sign_q  <= 1'b0;
      a_seen_q  <= 1'b0;
      b_seen_q  <= 1'b0;
      add_sub_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      a_sign_q  <= a_sign_d;
      b_sign_q  <= b_sign_d;
      a_seen_q  <= a_seen_d;
      b_seen_q  <= b_seen_d;
      add_sub_q <= add_sub_d;
      err_q     <= err_d;
    end
  end

  // A zero magnitude is always presented as +0.
  assign a1        = {a_sign_q && (a_mag_q != '0), a_mag_q};
  assign b1        = {b_sign_q && (b_mag_q != '0), b_mag_q};
  assign add_sub   = add_sub_q;
  assign out_valid = (state_q == ST_PRESENT);
  assign err       = err_q;
  assign entry_st  = state_q;

endmodule
`default_nettype wire
